// File: rtl/grf_pkg.sv
// Shared constants for the multi-port general register file and its
// pending-write scoreboard.
package grf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_WR     = 2;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending-write counters for the register file.
// An issue adds one to cnt[iss_addr]. Each accepted write subtracts one.
// The count floors at zero. rd_busy and iss_full both see same-cycle
// decrements, so a register whose last producer writes back this cycle
// is already reported as not busy.
// Issue handshake: iss_en is a request. It is accepted on a clock edge only
// when stall is low, iss_full is low and iss_addr is not register 0.
// Upstream must hold the instruction while iss_full is high.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 3,
  parameter int CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     stall,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     iss_full
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int SW    = CNT_W + 2;
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [DEPTH];
  logic [CNT_W-1:0]  cnt_d [DEPTH];
  logic [1:0]        dec   [DEPTH];
  logic [ADDR_W-1:0] wa    [NUM_WR];
  logic [ADDR_W-1:0] rsel  [NUM_RD];
  logic              iss_acc;

  // Add the increment, remove the decrements, and floor the result at zero.
  function automatic logic [CNT_W-1:0] net_cnt(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic [1:0] d);
    logic [SW-1:0] up;
    logic [SW-1:0] dn;
    up = SW'(cur) + SW'(inc);
    dn = SW'(d);
    if (up <= dn) net_cnt = '0;
    else          net_cnt = CNT_W'(up - dn);
  endfunction

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wa
    assign wa[p] = wr_addr[p*ADDR_W +: ADDR_W];
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign rsel[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  // Count the accepted writes to each register in this cycle.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      dec[r] = 2'd0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (!stall && wr_en[p] && wa[p] == ADDR_W'(r) && wa[p] != ZERO_A)
          dec[r] = dec[r] + 2'd1;
      end
    end
  end

  // Issue acceptance, the full flag and the busy flags seen by the stall unit.
  always_comb begin
    iss_full = (cnt_q[iss_addr] == CNT_MAX) && (dec[iss_addr] == 2'd0);
    iss_acc  = iss_en && !stall && !iss_full && (iss_addr != ZERO_A);
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = (rsel[k] != ZERO_A) &&
                   (net_cnt(cnt_q[rsel[k]], 1'b0, dec[rsel[k]]) != '0);
    end
  end

  // Next counter values. With stall high there is no increment or decrement.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = net_cnt(cnt_q[r], iss_acc && (iss_addr == ADDR_W'(r)), dec[r]);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < DEPTH; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/grf_mp.sv
// Multi-port general register file for the ID stage.
// Write port 0 comes from the MEM-side early writeback and write port 1
// comes from WB. Port 1 wins when both ports write the same address.
// Register 0 always reads zero and is never written.
// Reads are combinational. Define GRF_BYPASS_EN to forward same-cycle write
// data to the read ports (write-through). Without it, a read returns the
// array contents from before the write.
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 3,
  parameter int CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     stall,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_full
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q  [DEPTH];
  logic [DATA_W-1:0] regs_d  [DEPTH];
  logic [ADDR_W-1:0] wa      [NUM_WR];
  logic [DATA_W-1:0] wd      [NUM_WR];
  logic [ADDR_W-1:0] rsel    [NUM_RD];
  logic [DATA_W-1:0] rd_word [NUM_RD];

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    assign wa[p] = wr_addr[p*ADDR_W +: ADDR_W];
    assign wd[p] = wr_data[p*DATA_W +: DATA_W];
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rsel[k]                     = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] = rd_word[k];
  end

  // Next array contents. Ports are applied in ascending order, so port 1
  // overrides port 0 on the same address.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      for (int p = 0; p < NUM_WR; p++) begin
        if (!stall && wr_en[p] && wa[p] == ADDR_W'(r) && wa[p] != ZERO_A)
          regs_d[r] = wd[p];
      end
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read mux, with optional forwarding of same-cycle write data.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_word[k] = (rsel[k] == ZERO_A) ? '0 : regs_q[rsel[k]];
`ifdef GRF_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (!stall && wr_en[p] && wa[p] == rsel[k] && rsel[k] != ZERO_A)
          rd_word[k] = wd[p];
      end
`endif
    end
  end

  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .iss_full (iss_full)
  );
endmodule

// File: tb/tb_grf_mp.sv
// Randomized bench for grf_mp with a reference model of the register file.
// The model keeps the register values and pending-write counts as plain
// arrays and applies the issue and writeback rules with integer arithmetic.
module tb_grf_mp;
  import grf_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 3;
  localparam int CW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk     = 1'b0;
  logic             Reset_n = 1'b0;
  logic             stall   = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [1:0]       wr_en   = '0;
  logic [2*AW-1:0]  wr_addr = '0;
  logic [2*DW-1:0]  wr_data = '0;
  logic             iss_en  = 1'b0;
  logic [AW-1:0]    iss_addr = '0;
  logic             iss_full;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt [DEPTH];

  // Clock and reset.
  always #5 clk = ~clk;

  grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) dut (
    .clk      (clk),
    .Reset_n  (Reset_n),
    .stall    (stall),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_full (iss_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model.
  function automatic logic [AW-1:0] ra(input int k);
    return rd_addr[k*AW +: AW];
  endfunction

  function automatic int n_acc(input logic [AW-1:0] a);
    int n = 0;
    if (!stall && a != 0) begin
      if (wr_en[0] && wr_addr[AW-1:0] == a)    n++;
      if (wr_en[1] && wr_addr[2*AW-1:AW] == a) n++;
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = (a == 0) ? '0 : m_mem[a];
`ifdef GRF_BYPASS_EN
    if (!stall && a != 0) begin
      if (wr_en[0] && wr_addr[AW-1:0] == a)    v = wr_data[DW-1:0];
      if (wr_en[1] && wr_addr[2*AW-1:AW] == a) v = wr_data[2*DW-1:DW];
    end
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return (a != 0) && ((m_cnt[a] - n_acc(a)) > 0);
  endfunction

  function automatic logic exp_full();
    return (m_cnt[iss_addr] == CMAX) && (n_acc(iss_addr) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    logic full;
    int   c;
    full = exp_full();
    if (Reset_n && !stall) begin
      for (int r = 1; r < DEPTH; r++) begin
        c = m_cnt[r] - n_acc(AW'(r));
        if (iss_en && !full && iss_addr == AW'(r)) c++;
        m_cnt[r] = (c < 0) ? 0 : c;
      end
      if (wr_en[0] && wr_addr[AW-1:0] != 0)    m_mem[wr_addr[AW-1:0]]    = wr_data[DW-1:0];
      if (wr_en[1] && wr_addr[2*AW-1:AW] != 0) m_mem[wr_addr[2*AW-1:AW]] = wr_data[2*DW-1:DW];
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rd_data%0d", k), rd_data[k*DW +: DW], exp_rd(ra(k)));
      check($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'(exp_busy(ra(k))));
    end
    check("iss_full", 32'(iss_full), 32'(exp_full()));
  endtask

  // Driver tasks.
  task automatic cyc();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    stall  = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*DW +: DW]  = d;
  endtask

  task automatic setrd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    iss_en   = 1'b1;
    iss_addr = a;
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data0", rd_data[DW-1:0], 32'h0);
    check("rst_busy", 32'(rd_busy), 32'h0);
    check("rst_full", 32'(iss_full), 32'h0);
    Reset_n = 1'b1;

    // Port 0 write, then a write to register 0.
    idle(); wr(0, 5'd3, 32'hAAAA5555); setrd(0, 5'd3); cyc();
    idle(); #1; check("wr3", rd_data[DW-1:0], 32'hAAAA5555); cyc();
    wr(0, 5'd0, 32'hFFFFFFFF); setrd(0, 5'd0); cyc();
    idle(); #1; check("wr0", rd_data[DW-1:0], 32'h0); cyc();

    // Both ports write $7 in the same cycle.
    idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); setrd(1, 5'd7); #1;
`ifdef GRF_BYPASS_EN
    check("byp7", rd_data[2*DW-1:DW], 32'h22);
`else
    check("old7", rd_data[2*DW-1:DW], 32'h0);
`endif
    cyc();
    idle(); #1; check("wr7", rd_data[2*DW-1:DW], 32'h22); cyc();

    // Saturate $9, then drain it through port 1.
    idle(); iss(5'd9); setrd(2, 5'd9);
    repeat (3) cyc();
    idle(); iss_addr = 5'd9; #1;
    check("busy9", 32'(rd_busy[2]), 32'h1);
    check("full9", 32'(iss_full), 32'h1);
    iss_en = 1'b1; cyc();
    idle(); #1; check("full9_hold", 32'(iss_full), 32'h1);
    wr(1, 5'd9, 32'h901); cyc();
    wr(1, 5'd9, 32'h902); cyc();
    wr(1, 5'd9, 32'h903); #1;
    check("busy9_clr", 32'(rd_busy[2]), 32'h0);
    cyc();
    idle(); #1;
    check("busy9_after", 32'(rd_busy[2]), 32'h0);
    check("full9_after", 32'(iss_full), 32'h0);
    cyc();

    // Stall freezes array, counters and bypass.
    idle(); wr(0, 5'd4, 32'h44); cyc();
    idle(); stall = 1'b1; wr(0, 5'd4, 32'h55); wr(1, 5'd4, 32'h55); iss(5'd4); setrd(0, 5'd4); #1;
    check("stall_byp4", rd_data[DW-1:0], 32'h44);
    cyc();
    idle(); #1;
    check("stall_data4", rd_data[DW-1:0], 32'h44);
    check("stall_busy4", 32'(rd_busy[0]), 32'h0);
    cyc();

    // Issue and writeback of $6 in the same cycle with one write pending.
    idle(); iss(5'd6); setrd(1, 5'd6); cyc();
    iss(5'd6); wr(0, 5'd6, 32'h66); cyc();
    idle(); #1; check("iw6_busy", 32'(rd_busy[1]), 32'h1); cyc();
    wr(0, 5'd6, 32'h67); cyc();
    idle(); cyc();

    // Asynchronous reset in the middle of a cycle.
    idle(); wr(0, 5'd5, 32'h1234); cyc();
    idle(); iss(5'd5); cyc();
    idle(); iss_addr = 5'd5; setrd(0, 5'd5); #1;
    check("pre_rst_busy5", 32'(rd_busy[0]), 32'h1);
    #1; Reset_n = 1'b0; #1;
    check("rst_data5", rd_data[DW-1:0], 32'h0);
    check("rst_busy5", 32'(rd_busy[0]), 32'h0);
    check("rst_full5", 32'(iss_full), 32'h0);
    model_reset();
    cyc();
    Reset_n = 1'b1;
    cyc();

    // Random traffic.
    repeat (600) begin
      stall    = ($urandom_range(0, 7) == 0);
      wr_en[0] = ($urandom_range(0, 2) == 0);
      wr_en[1] = ($urandom_range(0, 2) == 0);
      wr_addr  = {raddr(), raddr()};
      wr_data  = {32'($urandom), 32'($urandom)};
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = raddr();
      rd_addr  = {raddr(), raddr(), raddr()};
      cyc();
    end

    idle(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
